// File: rtl/ext_mem_responder.sv
// ext_mem_responder
// Word-addressed external memory responder for the CPU bus. It owns the MAR
// address pointer, stores a 2**ADDR_W x DATA_W array, returns read data with a
// one-cycle valid pulse, and stops serving traffic once the CPU halts.
//
// Build option: define BUS_WAIT_STATE_EN to insert one wait state (RD_WAIT)
// into every read. Without it, reads complete at the edge that samples them,
// and o_busy is high only while halted.
module ext_mem_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mar_load,
  input  logic [ADDR_W-1:0] i_mar_addr,
  input  logic              i_mar_increment,
  input  logic              i_rd_req,
  input  logic              i_wr_req,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_halt,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef BUS_WAIT_STATE_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HALTED  = 2'd2
  } state_t;
`endif

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] eff_addr;
  logic              err_q;
  logic              err_d;
  logic              req_any;
  logic              req_conflict;
  logic              rd_go;
  logic              wr_go;

  // Storage: deliberately not reset, contents undefined until written.
  logic [DATA_W-1:0] mem [DEPTH];

  // Read return stage
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;

`ifdef BUS_WAIT_STATE_EN
  logic              rd_done;
  logic [ADDR_W-1:0] rd_addr_p0;
`endif

  // Access address and candidate pointer value; load has priority over increment.
  always_comb begin
    eff_addr     = i_mar_load ? i_mar_addr : addr_q;
    addr_next    = addr_q;
    if (i_mar_load) begin
      addr_next  = i_mar_addr;
    end else if (i_mar_increment) begin
      addr_next  = addr_q + ADDR_ONE;
    end
    req_any      = i_rd_req | i_wr_req;
    req_conflict = i_rd_req & i_wr_req;
  end

  // Next-state, pointer, error and access-strobe decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    rd_go   = 1'b0;
    wr_go   = 1'b0;
`ifdef BUS_WAIT_STATE_EN
    rd_done = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (i_halt) begin
          // Halt wins over any request seen on the same edge; pointer freezes.
          state_d = HALTED;
          if (req_any) err_d = 1'b1;
        end else begin
          if (req_conflict) begin
            err_d = 1'b1;
          end else if (i_rd_req) begin
            rd_go = 1'b1;
`ifdef BUS_WAIT_STATE_EN
            state_d = RD_WAIT;
`endif
          end else if (i_wr_req) begin
            wr_go = 1'b1;
          end
          addr_d = addr_next;
        end
      end
`ifdef BUS_WAIT_STATE_EN
      RD_WAIT: begin
        if (i_halt) begin
          // Abort the captured read: no data, no valid pulse.
          state_d = HALTED;
          if (req_any) err_d = 1'b1;
        end else begin
          rd_done = 1'b1;
          state_d = IDLE;
          if (req_any) err_d = 1'b1;
          // Access address is already captured, so the pointer may move freely.
          addr_d  = addr_next;
        end
      end
`endif
      HALTED: begin
        if (req_any) err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers: state, address pointer, sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Memory write port: writes land at the edge that samples them.
  always_ff @(posedge i_clk) begin
    if (wr_go) begin
      mem[eff_addr] <= i_wr_data;
    end
  end

`ifdef BUS_WAIT_STATE_EN
  // Capture the read address at acceptance for use after the wait state.
  always_ff @(posedge i_clk) begin
    if (rd_go) begin
      rd_addr_p0 <= eff_addr;
    end
  end

  // Read return: data and valid pulse at the edge ending RD_WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_done;
      if (rd_done) begin
        rd_data_p1 <= mem[rd_addr_p0];
      end
    end
  end

  assign o_busy = (state_q != IDLE);
`else
  // Read return: data and valid pulse at the edge that samples the request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= rd_go;
      if (rd_go) begin
        rd_data_p1 <= mem[eff_addr];
      end
    end
  end

  assign o_busy = (state_q == HALTED);
`endif

  assign o_rd_data  = rd_data_p1;
  assign o_rd_valid = vld_p1;
  assign o_addr     = addr_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Testbench for ext_mem_responder: randomized bus traffic against a
// behavioural memory model, with a queue-based scoreboard for read returns.
module tb_ext_mem_responder;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
`ifdef BUS_WAIT_STATE_EN
  localparam int LAT     = 1;
  localparam bit WAIT_EN = 1'b1;
`else
  localparam int LAT     = 0;
  localparam bit WAIT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mar_load = 1'b0;
  logic [ADDR_W-1:0] mar_addr = '0;
  logic              inc = 1'b0;
  logic              rd = 1'b0;
  logic              wr = 1'b0;
  logic [DATA_W-1:0] wdata = '0;
  logic              halt = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic              err;

  ext_mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_mar_load      (mar_load),
    .i_mar_addr      (mar_addr),
    .i_mar_increment (inc),
    .i_rd_req        (rd),
    .i_wr_req        (wr),
    .i_wr_data       (wdata),
    .i_halt          (halt),
    .o_rd_data       (rd_data),
    .o_rd_valid      (rd_valid),
    .o_busy          (busy),
    .o_addr          (addr),
    .o_err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [ADDR_W-1:0] m_ptr = '0;
  bit                m_err = 1'b0;
  bit                m_halted = 1'b0;
  bit                m_wait = 1'b0;
  int                cyc = 0;
  int                n_checks = 0;
  int                n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: applies one clock edge of bus traffic to the abstract state.
  task automatic model_edge();
    logic [ADDR_W-1:0] eff;
    bit                req;
    exp_t              e;
    eff = mar_load ? mar_addr : m_ptr;
    req = rd || wr;
    if (m_halted) begin
      if (req) m_err = 1'b1;
    end else if (halt) begin
      if (req) m_err = 1'b1;
      if (m_wait) begin
        void'(exp_q.pop_back());
        m_wait = 1'b0;
      end
      m_halted = 1'b1;
    end else begin
      if (m_wait) begin
        if (req) m_err = 1'b1;
        m_wait = 1'b0;
      end else if (rd && wr) begin
        m_err = 1'b1;
      end else if (rd) begin
        e.data = m_mem[eff];
        e.due  = cyc + LAT;
        exp_q.push_back(e);
        m_wait = WAIT_EN;
      end else if (wr) begin
        m_mem[eff] = wdata;
      end
      if (mar_load) m_ptr = mar_addr;
      else if (inc) m_ptr = m_ptr + 8'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("o_addr", 32'(addr), 32'(m_ptr));
    chk("o_err", 32'(err), 32'(m_err));
    chk("o_busy", 32'(busy), 32'(m_halted || m_wait));
  endtask

  task automatic op(input bit ld, input logic [ADDR_W-1:0] a, input bit in, input bit r,
                    input bit w, input logic [DATA_W-1:0] d, input bit h);
    mar_load = ld;
    mar_addr = a;
    inc      = in;
    rd       = r;
    wr       = w;
    wdata    = d;
    halt     = h;
    step();
    mar_load = 1'b0;
    inc      = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
    halt     = 1'b0;
  endtask

  // Read that leaves room for the wait state when it exists.
  task automatic rd_op(input bit ld, input logic [ADDR_W-1:0] a, input bit in);
    op(ld, a, in, 1'b1, 1'b0, '0, 1'b0);
    if (WAIT_EN) op(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'h0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_addr"}, 32'(addr), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from both edges.
  task automatic reset_mid(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    exp_q.delete();
    m_ptr    = '0;
    m_err    = 1'b0;
    m_halted = 1'b0;
    m_wait   = 1'b0;
    @(posedge clk);
    cyc++;
    #3 rst_n = 1'b1;
  endtask

  // Monitor: every cycle, the valid pulse must match the scoreboard head.
  always @(negedge clk) begin
    bit want;
    exp_t e;
    want = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("rd_valid", 32'(rd_valid), 32'(want));
    if (want) begin
      e = exp_q.pop_front();
      if (rd_valid) chk("rd_data", 32'(rd_data), 32'(e.data));
    end
  end

  initial begin
    int r;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    #2 rst_n = 1'b1;

    // Preload the whole array through the bus so every word is defined.
    for (int i = 0; i < DEPTH; i++) begin
      op(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, (i == 16'h10) ? 16'hA5A5 : 16'($urandom), 1'b0);
    end

    // Load 0x10 together with a read.
    rd_op(1'b1, 8'h10, 1'b0);
    chk("addr_after_load", 32'(addr), 32'h10);

    // Post-increment reads across the wrap point.
    op(1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (4) rd_op(1'b0, '0, 1'b1);
    chk("addr_wrapped", 32'(addr), 32'h02);

    // Write then read back; then a conflicting rd+wr must leave the word alone.
    op(1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
    rd_op(1'b1, 8'h20, 1'b0);
    chk("err_before_conflict", 32'(err), 32'h0);
    op(1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b0);
    chk("err_after_conflict", 32'(err), 32'h1);
    rd_op(1'b1, 8'h20, 1'b0);

    // Reset while a read is outstanding.
    op(1'b1, 8'h40, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    reset_mid("rst_mid_read");

    // Second read while the first is still in its wait state.
    if (WAIT_EN) begin
      op(1'b1, 8'h30, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      chk("busy_in_wait", 32'(busy), 32'h1);
      op(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      chk("err_read_while_busy", 32'(err), 32'h1);
      op(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      reset_mid("rst_after_busy");
    end

    // Random traffic, no halt.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      op($urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 9) < 4,
         (r < 35) || (r >= 98), ((r >= 35) && (r < 65)) || (r >= 98), 16'($urandom), 1'b0);
    end
    repeat (2) op(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Halt directly after a read: later traffic is refused, pointer frozen.
    op(1'b1, 8'h50, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    op(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int n = 0; n < 6; n++) begin
      op(1'b1, 8'($urandom), 1'b1, n[0], !n[0], 16'($urandom), 1'b0);
    end
    chk("busy_halted", 32'(busy), 32'h1);
    chk("err_halted", 32'(err), 32'h1);
    repeat (3) op(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    reset_mid("rst_from_halt");

    @(negedge clk);
    #1;
    chk("pending_reads", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
